// File: rtl/mat_result_reader_pkg.sv
// rtl/mat_result_reader_pkg.sv - shared constants, phase codes and FSM encoding for mat_result_reader
package mat_result_reader_pkg;

    localparam int WORD_LEN  = 16;
    localparam int DIM       = 8;
    localparam int ADDR_BITS = 7;
    localparam int DEPTH     = DIM * DIM;
    localparam int CNT_BITS  = $clog2(DEPTH);
    localparam int ROW_BITS  = $clog2(DIM);

    localparam logic REAL_SET = 1'b0;
    localparam logic IMAG_SET = 1'b1;

    localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CAP_REAL = 3'd1,
        CAP_IMAG = 3'd2,
        FETCH    = 3'd3,
        DRAIN    = 3'd4
    } rr_state_t;

    // Buffers are row-major, so the row is the upper index bits and the column the lower.
    function automatic logic [ROW_BITS-1:0] cnt_row(input logic [CNT_BITS-1:0] cnt);
        return cnt[CNT_BITS-1 -: ROW_BITS];
    endfunction

    function automatic logic [ROW_BITS-1:0] cnt_col(input logic [CNT_BITS-1:0] cnt);
        return cnt[ROW_BITS-1:0];
    endfunction

endpackage

// File: rtl/mat_result_reader_if.sv
// rtl/mat_result_reader_if.sv - complex result pair stream with valid/ready handshake
interface mat_result_reader_if;
    import mat_result_reader_pkg::*;

    logic                       out_valid;
    logic                       out_ready;
    logic signed [WORD_LEN-1:0] out_real;
    logic signed [WORD_LEN-1:0] out_imag;
    logic [ROW_BITS-1:0]        out_row;
    logic [ROW_BITS-1:0]        out_col;
    logic                       out_last;

    modport master (
        output out_valid, out_real, out_imag, out_row, out_col, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_real, out_imag, out_row, out_col, out_last,
        output out_ready
    );

endinterface

// File: rtl/mat_result_reader_coef_buf.sv
// rtl/mat_result_reader_coef_buf.sv - single-write, registered-read coefficient RAM
module mat_result_reader_coef_buf #(
    parameter int WIDTH = 16,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [2**AW];

    // Storage is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the read register clears; it holds its value whenever rd_en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/mat_result_reader.sv
// rtl/mat_result_reader.sv - captures real/imag coefficient phases and replays them as complex pairs
module mat_result_reader
    import mat_result_reader_pkg::*;
(
    input  logic                       src_clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       state,
    input  logic                       coef_valid,
    input  logic signed [WORD_LEN-1:0] coefficient,
    mat_result_reader_if.master        res,
    output logic                       busy,
    output logic                       done,
    output logic                       err_phase,
    output logic                       err_ovf
);

    if ((2 ** ADDR_BITS) < DEPTH) begin : g_addr_bits_check
        $error("ADDR_BITS cannot address DIM*DIM coefficients");
    end

    rr_state_t           fsm_q, fsm_d;
    logic [CNT_BITS-1:0] wr_cnt;
    logic [CNT_BITS-1:0] rd_cnt;

    logic                wr_real, wr_imag;
    logic                bad_phase, overflow;
    logic                hs, adv, last_hs;
    logic                rd_en;
    logic [CNT_BITS-1:0] rd_addr;

    assign wr_real   = (fsm_q == CAP_REAL) && coef_valid && (state == REAL_SET);
    assign wr_imag   = (fsm_q == CAP_IMAG) && coef_valid && (state == IMAG_SET);
    assign bad_phase = coef_valid && (((fsm_q == CAP_REAL) && (state != REAL_SET)) ||
                                      ((fsm_q == CAP_IMAG) && (state != IMAG_SET)));
    assign overflow  = coef_valid && ((fsm_q == FETCH) || (fsm_q == DRAIN));

    assign hs      = (fsm_q == DRAIN) && res.out_ready;
    assign adv     = hs && (rd_cnt != CNT_MAX);
    assign last_hs = hs && (rd_cnt == CNT_MAX);

    // Read one address ahead on every accepted pair so a new pair is ready each clock.
    assign rd_en   = (fsm_q == FETCH) || adv;
    assign rd_addr = (fsm_q == FETCH) ? rd_cnt : rd_cnt + CNT_BITS'(1);

    always_ff @(posedge src_clk) begin
        if (rst) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            IDLE:     if (start) fsm_d = CAP_REAL;
            CAP_REAL: if (wr_real && (wr_cnt == CNT_MAX)) fsm_d = CAP_IMAG;
            CAP_IMAG: if (wr_imag && (wr_cnt == CNT_MAX)) fsm_d = FETCH;
            FETCH:    fsm_d = DRAIN;
            DRAIN:    if (last_hs) fsm_d = IDLE;
            default:  fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge src_clk) begin
        if (rst) begin
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            done      <= 1'b0;
            err_phase <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            done <= last_hs;
            if ((fsm_q == IDLE) && start) begin
                wr_cnt    <= '0;
                err_phase <= 1'b0;
                err_ovf   <= 1'b0;
            end
            // wr_cnt wraps naturally after the 64th write of each phase.
            if (wr_real || wr_imag) begin
                wr_cnt <= wr_cnt + CNT_BITS'(1);
            end
            if (bad_phase) begin
                err_phase <= 1'b1;
            end
            if (overflow) begin
                err_ovf <= 1'b1;
            end
            if (wr_imag && (wr_cnt == CNT_MAX)) begin
                rd_cnt <= '0;
            end else if (adv) begin
                rd_cnt <= rd_cnt + CNT_BITS'(1);
            end
        end
    end

    mat_result_reader_coef_buf #(
        .WIDTH (WORD_LEN),
        .AW    (CNT_BITS)
    ) u_real_buf (
        .clk     (src_clk),
        .rst     (rst),
        .wr_en   (wr_real),
        .wr_addr (wr_cnt),
        .wr_data (coefficient),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (res.out_real)
    );

    mat_result_reader_coef_buf #(
        .WIDTH (WORD_LEN),
        .AW    (CNT_BITS)
    ) u_imag_buf (
        .clk     (src_clk),
        .rst     (rst),
        .wr_en   (wr_imag),
        .wr_addr (wr_cnt),
        .wr_data (coefficient),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (res.out_imag)
    );

    assign busy          = (fsm_q != IDLE);
    assign res.out_valid = (fsm_q == DRAIN);
    assign res.out_last  = res.out_valid && (rd_cnt == CNT_MAX);
    assign res.out_row   = cnt_row(rd_cnt);
    assign res.out_col   = cnt_col(rd_cnt);

endmodule

// File: doc/mat_result_reader.md
Name: mat_result_reader

Overview:
- Drain-side companion of full_mult: captures the serial complex coefficient stream (64 real words in the REAL_SET phase, then 64 imaginary words in the IMAG_SET phase) into two internal 8x8 buffers.
- Replays the result as complex pairs (real, imag, row, col) over a valid/ready handshake toward the host or bench checker.
- Sits between the full_mult coefficient output and downstream consumers; this is the read-back end of the matrix load interface.

Parameters:
- WORD_LEN, 16, coefficient width in bits (signed, two's complement); matches the WORD_LEN macro.
- DIM, 8, matrix dimension; buffer depth is DIM*DIM = 64.
- ADDR_BITS, 7, buffer address width; matches the ADDR_BITS macro; must satisfy 2^ADDR_BITS >= DIM*DIM.

Ports:
- src_clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; arms capture; honoured only in IDLE.
- state  in  1  phase from the controller: REAL_SET or IMAG_SET (macro values).
- coef_valid  in  1  coefficient qualifier from full_mult.
- coefficient  in  WORD_LEN  signed coefficient.
- out_valid  out  1  output pair valid.
- out_ready  in  1  consumer accepts.
- out_real  out  WORD_LEN  real part.
- out_imag  out  WORD_LEN  imaginary part.
- out_row  out  3  row index (log2 DIM).
- out_col  out  3  column index.
- out_last  out  1  high with the final pair (row 7, col 7).
- busy  out  1  high whenever not in IDLE.
- done  out  1  one-cycle pulse after the last pair handshakes.
- err_phase  out  1  sticky; a coefficient arrived with a state not matching the capture phase.
- err_ovf  out  1  sticky; a coefficient arrived after the phase buffer was full.

Behaviour:
- Reset (rst=1 at a src_clk edge): FSM goes to IDLE; all counters go to 0; out_valid, out_last, busy, done, err_phase, err_ovf, out_real, out_imag, out_row and out_col go to 0. Buffer contents are not reset. A reset mid-operation aborts without emitting done.
- FSM states: IDLE, CAP_REAL, CAP_IMAG, FETCH, DRAIN.
- IDLE: start=1 moves to CAP_REAL, clears wr_cnt and both error flags, and raises busy on the next cycle.
- CAP_REAL:
  - A cycle with coef_valid=1 and state=REAL_SET writes coefficient to real_buf[wr_cnt], then increments wr_cnt.
  - When wr_cnt reaches 63 with a write, wr_cnt wraps to 0 and the FSM moves to CAP_IMAG.
- CAP_IMAG: same rule with state=IMAG_SET into imag_buf. After the 64th write the FSM moves to FETCH and clears rd_cnt.
- Phase mismatch: coef_valid=1 with the wrong state is dropped, err_phase is set, and wr_cnt is unchanged.
- Overflow: coef_valid=1 in FETCH or DRAIN is dropped and err_ovf is set. In IDLE, coef_valid is ignored silently.
- Buffer write ordering: row-major, address = row*8 + col.
- FETCH:
  - One cycle; a registered synchronous read of both buffers at rd_cnt.
  - The next cycle enters DRAIN with out_valid=1 and the outputs loaded.
  - Latency: the first out_valid appears 2 cycles after the 64th imaginary write.
- DRAIN handshake:
  - The outputs hold stable while out_valid=1 and out_ready=0.
  - On out_valid and out_ready both high with rd_cnt<63, rd_cnt increments and the next pair presents on the following cycle (prefetched read). Sustained throughput is 1 pair per clock.
  - out_row = rd_cnt[5:3] and out_col = rd_cnt[2:0].
  - out_last = 1 exactly when rd_cnt = 63.
  - The handshake of the last pair drops out_valid, pulses done for one cycle, and returns to IDLE.
- start pulses while busy=1 are ignored.
- No arithmetic is performed; widths pass through unchanged. Sign is preserved bit-exact.

Decomposition:
- Shared package/macro file (extends the existing macro file): REAL_SET and IMAG_SET encodings, WORD_LEN, ADDR_BITS, DIM, and the FSM state encodings for mat_result_reader.
- One natural sub-module: coef_buf, a 64 x WORD_LEN single-write, single registered-read RAM, instantiated twice (real and imag).

Test Plan:
- Basic round-trip: start, then 64 REAL_SET coefficients 0x0000..0x003F, then 64 IMAG_SET coefficients 0x8000..0x803F, out_ready=1 -> 64 pairs in order; pair k = (k, 0x8000+k, row k/8, col k%8); out_last only on k=63; done pulses once; busy=0 afterwards.
- Back-pressure: same load with out_ready toggling 1,0,0,1... -> no pair lost or duplicated; outputs stable during every stall; done after exactly 64 handshakes.
- Phase error: during CAP_REAL, inject one coef_valid with state=IMAG_SET, value 0x7FFF -> err_phase=1; value not stored; real buffer still holds 0x0000..0x003F.
- Overflow: a 65th IMAG_SET coefficient while in FETCH/DRAIN -> err_ovf=1; drained data unaffected.
- Reset mid-op: assert rst after 30 real writes -> the next cycle shows busy=0, out_valid=0, no done. A fresh start then captures and drains correctly.
- Signed extremes: real words 0x8000 and 0x7FFF at addresses 0 and 63 -> read back bit-exact at (row 0, col 0) and (row 7, col 7).
